// File: rtl/alu4_seq_ctrl_pkg.sv
// Shared types and constants for the alu4 command sequencer: widths, FSM encoding,
// add/sub selector values and the operand-b mux helper. No logic, no latency.
package alu4_seq_ctrl_pkg;

    localparam int DATA_W = 4;
    localparam int NREGS  = 4;
    localparam int ADDR_W = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Result fields captured from the ALU in EXEC and held through RESP.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              zero;
        logic              overflow;
    } rsp_t;

    function automatic logic [DATA_W-1:0] sel_b(
        input logic              b_imm,
        input logic [DATA_W-1:0] imm,
        input logic [DATA_W-1:0] rs2_val
    );
        return b_imm ? imm : rs2_val;
    endfunction

endpackage

// File: rtl/alu4_regfile.sv
// NREGS x DATA_W register file: two combinational read ports, one write port (1-cycle),
// async clear; r0 optionally hardwired to zero. No backpressure.
module alu4_regfile #(
    parameter int NREGS     = 4,
    parameter int DATA_W    = 4,
    parameter int REG0_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] raddr1,
    input  logic [$clog2(NREGS)-1:0] raddr2,
    output logic [DATA_W-1:0]        rdata1,
    output logic [DATA_W-1:0]        rdata2,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_en;

    assign wr_en = we && !((REG0_ZERO != 0) && (waddr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // r0 is masked on the read side too, so it reads zero regardless of storage.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if ((REG0_ZERO != 0) && (raddr1 == '0)) rdata1 = '0;
        if ((REG0_ZERO != 0) && (raddr2 == '0)) rdata2 = '0;
    end

endmodule

// File: rtl/alu4_seq_ctrl.sv
// Serialised command sequencer for the alu4 slice: register-file operand fetch, ALU drive, write-back.
// Accept at edge T, rsp_valid from T+2 (3 cycles/cmd min); cmd_ready low until the response is taken.
module alu4_seq_ctrl #(
    parameter int DATA_W    = alu4_seq_ctrl_pkg::DATA_W,
    parameter int NREGS     = alu4_seq_ctrl_pkg::NREGS,
    parameter int REG0_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic                     cmd_add_sub,
    input  logic [DATA_W-1:0]        cmd_i3,
    input  logic [$clog2(NREGS)-1:0] cmd_rd,
    input  logic [$clog2(NREGS)-1:0] cmd_rs1,
    input  logic [$clog2(NREGS)-1:0] cmd_rs2,
    input  logic                     cmd_b_imm,
    input  logic [DATA_W-1:0]        cmd_imm,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_zero,
    output logic                     rsp_overflow,
    output logic                     sticky_ovf,
    input  logic                     clr_sticky,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [DATA_W-1:0]        alu_i3,
    output logic [1:0]               alu_op,
    output logic                     alu_add_sub,
    input  logic [DATA_W-1:0]        alu_f,
    input  logic                     alu_zero,
    input  logic                     alu_overflow
);

    import alu4_seq_ctrl_pkg::*;

    localparam int AW = $clog2(NREGS);

    state_t            state_q;
    state_t            state_d;
    logic              cmd_fire;
    logic              exec_cap;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    rsp_t              rsp_q;

    alu4_regfile #(
        .NREGS     (NREGS),
        .DATA_W    (DATA_W),
        .REG0_ZERO (REG0_ZERO)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (cmd_rs1),
        .raddr2 (cmd_rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (exec_cap),
        .waddr  (rd_q),
        .wdata  (alu_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cmd_ready is gated by rst directly so it is low for the whole reset pulse.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        cmd_fire  = 1'b0;
        exec_cap  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    cmd_fire = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                exec_cap = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ALU drive registers only move on an accepted command; they hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_i3      <= '0;
            alu_op      <= '0;
            alu_add_sub <= ADD;
            rd_q        <= '0;
        end else if (cmd_fire) begin
            alu_a       <= rs1_val;
            alu_b       <= sel_b(cmd_b_imm, cmd_imm, rs2_val);
            alu_i3      <= cmd_i3;
            alu_op      <= cmd_op;
            alu_add_sub <= cmd_add_sub;
            rd_q        <= cmd_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q <= '0;
        end else if (exec_cap) begin
            rsp_q.data     <= alu_f;
            rsp_q.zero     <= alu_zero;
            rsp_q.overflow <= alu_overflow;
        end
    end

    assign rsp_data     = rsp_q.data;
    assign rsp_zero     = rsp_q.zero;
    assign rsp_overflow = rsp_q.overflow;

    // A captured overflow takes priority over a simultaneous clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
        end else if (exec_cap && alu_overflow) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Closed-loop bench: behavioural 4-bit add/sub ALU on the alu_* ports, vector table plus
// scoreboard queue for responses, and hand sequences for backpressure, sticky and reset corners.
module tb_alu4_seq_ctrl;
    import alu4_seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_add_sub;
    logic [3:0] cmd_i3;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic       cmd_b_imm;
    logic [3:0] cmd_imm;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_zero, rsp_overflow;
    logic       sticky_ovf, clr_sticky;
    logic [3:0] alu_a, alu_b, alu_i3, alu_f;
    logic [1:0] alu_op;
    logic       alu_add_sub, alu_zero, alu_overflow;

    always #5 clk = ~clk;

    alu4_seq_ctrl #(.DATA_W(4), .NREGS(4), .REG0_ZERO(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_add_sub  (cmd_add_sub),
        .cmd_i3       (cmd_i3),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_b_imm    (cmd_b_imm),
        .cmd_imm      (cmd_imm),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .sticky_ovf   (sticky_ovf),
        .clr_sticky   (clr_sticky),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_i3       (alu_i3),
        .alu_op       (alu_op),
        .alu_add_sub  (alu_add_sub),
        .alu_f        (alu_f),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow)
    );

    // Behavioural ALU: add/sub with wrap, zero flag and two's-complement overflow.
    assign alu_f        = alu_add_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_zero     = (alu_f == 4'd0);
    assign alu_overflow = alu_add_sub ? ((alu_a[3] != alu_b[3]) && (alu_f[3] != alu_a[3]))
                                      : ((alu_a[3] == alu_b[3]) && (alu_f[3] != alu_a[3]));

    typedef struct {
        logic [1:0] rd, rs1, rs2;
        logic       b_imm;
        logic [3:0] imm;
        logic       add_sub;
        logic [1:0] op;
        logic [3:0] i3;
        logic [3:0] exp_a, exp_b, exp_f;
        logic       exp_z, exp_o;
        int         hold;
        logic       clr_after;
    } vec_t;

    typedef struct {
        logic [3:0] f;
        logic       z, o;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];
    vec_t v;
    int   errors = 0;
    int   checks = 0;
    logic exp_sticky = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] rd, rs1, rs2, input logic b_imm,
                                input logic [3:0] imm, input logic add_sub, input logic [1:0] op,
                                input logic [3:0] i3, input logic [3:0] ea, eb, ef,
                                input logic ez, eo, input int hold, input logic clr_after);
        vec_t r;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.b_imm = b_imm; r.imm = imm;
        r.add_sub = add_sub; r.op = op; r.i3 = i3;
        r.exp_a = ea; r.exp_b = eb; r.exp_f = ef; r.exp_z = ez; r.exp_o = eo;
        r.hold = hold; r.clr_after = clr_after;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input vec_t c);
        cmd_rd = c.rd; cmd_rs1 = c.rs1; cmd_rs2 = c.rs2; cmd_b_imm = c.b_imm;
        cmd_imm = c.imm; cmd_add_sub = c.add_sub; cmd_op = c.op; cmd_i3 = c.i3;
        cmd_valid = 1'b1;
    endtask

    // Returns 1 once the command has been accepted, 0 on timeout.
    task automatic accept(input vec_t c, output bit ok);
        int waits = 0;
        ok = 1'b0;
        drive_cmd(c);
        while (waits < 20) begin
            @(negedge clk);
            if (cmd_ready) break;
            waits++;
        end
        chk("accept_wait", 8'(waits), 8'd0);
        if (waits >= 20) begin
            cmd_valid = 1'b0;
            return;
        end
        step();
        cmd_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_cmd(input vec_t c, input bit clr_in_exec);
        bit ok;
        exp_t e;
        accept(c, ok);
        if (!ok) return;
        e.f = c.exp_f; e.z = c.exp_z; e.o = c.exp_o;
        sb.push_back(e);
        clr_sticky = clr_in_exec;
        @(negedge clk);
        chk("exec_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("exec_cmd_ready", 8'(cmd_ready), 8'd0);
        chk("alu_a", 8'(alu_a), 8'(c.exp_a));
        chk("alu_b", 8'(alu_b), 8'(c.exp_b));
        chk("alu_op", 8'(alu_op), 8'(c.op));
        chk("alu_i3", 8'(alu_i3), 8'(c.i3));
        chk("alu_add_sub", 8'(alu_add_sub), 8'(c.add_sub));
        step();
        clr_sticky = 1'b0;
        @(negedge clk);
        chk("latency_rsp_valid", 8'(rsp_valid), 8'd1);
        if (clr_in_exec) chk("sticky_set_wins", 8'(sticky_ovf), 8'd1);
        for (int h = 0; h < c.hold; h++) begin
            step();
            cmd_valid = 1'b1; cmd_b_imm = 1'b1; cmd_imm = ~c.exp_b; cmd_rs1 = 2'd3;
            @(negedge clk);
            chk("bp_rsp_valid", 8'(rsp_valid), 8'd1);
            chk("bp_rsp_data", 8'(rsp_data), 8'(c.exp_f));
            chk("bp_cmd_ready", 8'(cmd_ready), 8'd0);
            chk("bp_alu_b_held", 8'(alu_b), 8'(c.exp_b));
        end
        step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    // Scoreboard: pop at each response handshake (sampled on the falling edge).
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_rsp", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_data", 8'(rsp_data), 8'(e.f));
                chk("rsp_zero", 8'(rsp_zero), 8'(e.z));
                chk("rsp_overflow", 8'(rsp_overflow), 8'(e.o));
            end
        end
    end

    task automatic pulse_clr();
        step();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        exp_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", 8'(sticky_ovf), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        //            rd   rs1  rs2  bi  imm    as   op   i3     a      b      f      z  o  hold clr
        vecs[0] = mk(2'd1,2'd0,2'd0,1'b1,4'd5, ADD,2'd0,4'h3, 4'd0, 4'd5, 4'd5, 0, 0, 0, 0);
        vecs[1] = mk(2'd2,2'd1,2'd0,1'b1,4'd3, ADD,2'd1,4'hA, 4'd5, 4'd3, 4'd8, 0, 1, 0, 1);
        vecs[2] = mk(2'd3,2'd1,2'd1,1'b0,4'd0, SUB,2'd2,4'h5, 4'd5, 4'd5, 4'd0, 1, 0, 5, 0);
        vecs[3] = mk(2'd0,2'd1,2'd0,1'b1,4'd2, ADD,2'd3,4'hF, 4'd5, 4'd2, 4'd7, 0, 0, 0, 0);
        vecs[4] = mk(2'd1,2'd0,2'd2,1'b0,4'd0, ADD,2'd0,4'h1, 4'd0, 4'd8, 4'd8, 0, 0, 1, 0);
        vecs[5] = mk(2'd2,2'd2,2'd1,1'b0,4'd0, SUB,2'd1,4'h0, 4'd8, 4'd8, 4'd0, 1, 0, 0, 0);
        vecs[6] = mk(2'd3,2'd1,2'd0,1'b1,4'd1, SUB,2'd2,4'h9, 4'd8, 4'd1, 4'd7, 0, 1, 0, 0);
        vecs[7] = mk(2'd2,2'd3,2'd0,1'b1,4'd9, ADD,2'd3,4'h6, 4'd7, 4'd9, 4'd0, 1, 0, 0, 0);

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; clr_sticky = 1'b0;
        cmd_op = '0; cmd_add_sub = 1'b0; cmd_i3 = '0; cmd_rd = '0; cmd_rs1 = '0;
        cmd_rs2 = '0; cmd_b_imm = 1'b0; cmd_imm = '0;

        @(negedge clk);
        chk("rst_cmd_ready", 8'(cmd_ready), 8'd0);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_alu_a", 8'(alu_a), 8'd0);
        chk("rst_alu_b", 8'(alu_b), 8'd0);
        chk("rst_rsp_data", 8'(rsp_data), 8'd0);
        chk("rst_sticky", 8'(sticky_ovf), 8'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 8'(cmd_ready), 8'd1);
        step();

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i], 1'b0);
            exp_sticky = exp_sticky | vecs[i].exp_o;
            @(negedge clk);
            chk("sticky_after_cmd", 8'(sticky_ovf), 8'(exp_sticky));
            if (vecs[i].clr_after) pulse_clr();
            step();
        end

        // Overflow capture and clear in the same EXEC cycle: the set must win.
        pulse_clr();
        step();
        v = mk(2'd1, 2'd3, 2'd0, 1'b1, 4'd1, ADD, 2'd0, 4'h2, 4'd7, 4'd1, 4'd8, 0, 1, 0, 0);
        run_cmd(v, 1'b1);
        @(negedge clk);
        chk("sticky_after_collision", 8'(sticky_ovf), 8'd1);
        pulse_clr();
        step();

        // Reset while in EXEC: command abandoned, no write-back, register file cleared.
        v = mk(2'd1, 2'd3, 2'd0, 1'b1, 4'd2, ADD, 2'd0, 4'h0, 4'd7, 4'd2, 4'd9, 0, 1, 0, 0);
        accept(v, ok);
        if (ok) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk("midrst_rsp_valid", 8'(rsp_valid), 8'd0);
            chk("midrst_cmd_ready", 8'(cmd_ready), 8'd0);
            chk("midrst_alu_a", 8'(alu_a), 8'd0);
            chk("midrst_rsp_data", 8'(rsp_data), 8'd0);
            sb.delete();
            exp_sticky = 1'b0;
            step();
            step();
            rst = 1'b0;
            @(negedge clk);
            chk("postrst_cmd_ready", 8'(cmd_ready), 8'd1);
            step();
            v = mk(2'd2, 2'd1, 2'd3, 1'b0, 4'd0, ADD, 2'd1, 4'h4, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0);
            run_cmd(v, 1'b0);
            step();
        end

        step();
        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu4_seq_ctrl.md
Name: alu4_seq_ctrl

Overview:
Command sequencer and register file that sits directly upstream of the 4-bit ALU slice (alu4) and consumes its outputs.
- Accepts one operation per valid/ready handshake.
- Fetches operands from a 4x4-bit register file or an immediate, and drives the ALU operand/control inputs from registers.
- Captures f/zero/overflow, writes f back to the destination register, and returns the result on a valid/ready response channel.
- Keeps a sticky overflow flag for software polling.

Parameters:
DATA_W, 4, datapath width; must equal the ALU width. Only 4 is legal.
NREGS, 4, register file depth. Address width is log2(NREGS) = 2.
REG0_ZERO, 1, when 1: r0 always reads 0 and writes to r0 are dropped.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  passed unchanged to alu_op
cmd_add_sub  in  1  passed to alu_add_sub (0 add, 1 subtract)
cmd_i3  in  4  passed to alu_i3
cmd_rd  in  2  destination register
cmd_rs1  in  2  source register for operand a
cmd_rs2  in  2  source register for operand b
cmd_b_imm  in  1  1: b = cmd_imm; 0: b = reg[cmd_rs2]
cmd_imm  in  4  immediate operand
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  4  captured alu_f
rsp_zero  out  1  captured alu_zero
rsp_overflow  out  1  captured alu_overflow
sticky_ovf  out  1  set by any captured overflow
clr_sticky  in  1  synchronous clear of sticky_ovf
alu_a  out  4  to ALU operand a
alu_b  out  4  to ALU operand b
alu_i3  out  4  to ALU i3
alu_op  out  2  to ALU op
alu_add_sub  out  1  to ALU add_sub
alu_f  in  4  from ALU result
alu_zero  in  1  from ALU zero flag
alu_overflow  in  1  from ALU overflow flag

Behaviour:
- Reset (async, rst=1): state=IDLE; all registers, alu_* outputs, rsp_data/rsp_zero/rsp_overflow and sticky_ovf are 0; rsp_valid=0; cmd_ready forced 0 while rst is high.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: register the operands and controls onto alu_* (alu_a = reg[rs1], alu_b = imm or reg[rs2], op, add_sub, i3), latch rd, go to EXEC.
  - No handshake: alu_* outputs hold their previous values.
- EXEC (exactly 1 cycle):
  - The ALU is combinational; its outputs are sampled at the end of this cycle.
  - rsp_data/zero/overflow are latched from alu_f/zero/overflow; reg[rd] is written with alu_f (dropped if rd=0 and REG0_ZERO=1).
  - sticky_ovf is set if alu_overflow=1. Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On rsp_ready go to IDLE.
  - cmd_ready = 0 in EXEC and RESP.
- Latency: command accepted at edge T; rsp_valid high from T+2. Minimum 3 cycles per command.
- Register reads in IDLE see all prior write-backs. Commands are fully serialised, so no hazards exist.
- clr_sticky:
  - Clears sticky_ovf on the next edge in any state.
  - If asserted in the same cycle that EXEC captures overflow=1, set wins and sticky_ovf stays 1.
- Reset mid-operation (EXEC or RESP): the command is abandoned, no write-back occurs, rsp_valid drops immediately (async), and the register file clears.
- No width growth: 4-bit results wrap. Signed overflow is taken from the ALU only and never recomputed here.

Decomposition:
- Shared package: DATA_W, NREGS, address width, FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), and constants ADD=1'b0 / SUB=1'b1 for add_sub.
- One sub-module: alu4_regfile (NREGS x DATA_W, two combinational read ports, one synchronous write port, async reset, r0 hardwiring). FSM and flags stay in the top.
- The bench closes the loop by instantiating alu4, or a behavioural add/sub model, on the alu_* ports.

Test Plan:
- Load immediate: rd=1, rs1=0, b_imm=1, imm=5, add_sub=0 -> rsp_valid at T+2, rsp_data=5, zero=0, overflow=0; r1=5.
- Signed overflow: rd=2, rs1=1 (5), imm=3, add -> rsp_data=8 (4'b1000), overflow=1, sticky_ovf=1, r2=8. Then clr_sticky pulse -> sticky_ovf=0.
- Zero flag: rd=3, rs1=1, rs2=1, b_imm=0, add_sub=1 -> rsp_data=0, zero=1; r3=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, a second cmd_valid is not accepted. Release -> returns to IDLE and the next command is accepted the cycle after.
- r0 protection: rd=0, rs1=1, imm=2, add -> rsp_data=7; a subsequent read of r0 as rs1 gives alu_a=0.
- Reset mid-op: assert rst in EXEC -> rsp_valid=0, alu_a=0, regs=0, no write to rd. After release, cmd_ready=1 and r1 reads 0.
